// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - runtime-programmable divide-by-D tick generator with run/pause/one-shot control
module clk_div_ctrl #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned DEFAULT_DIV = 25_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TICK_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n_a,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
    input  logic [TICK_W-1:0] cfg_nticks,
    output logic              tick,
    output logic              clk_out,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  count;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_q;
    logic              clk_out_q;

    // Active configuration drives the counter; pending holds a request made while busy.
    logic [CNT_W-1:0]  act_div, pend_div;
    logic              act_oneshot, pend_oneshot;
    logic [TICK_W-1:0] act_nticks, pend_nticks;
    logic              pend_valid;

    logic              idle_like;
    logic              cfg_accept;
    logic [CNT_W-1:0]  cfg_div_clamped;
    logic              wrap;
    logic              complete;
    logic              launch;

    assign idle_like       = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cfg_accept      = cfg_valid && !pend_valid;
    assign cfg_div_clamped = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    // Period boundary: the edge that emits a tick, unless stop overrides it.
    assign wrap            = (state_q == S_RUN) && !stop && (count == act_div - CNT_W'(1));
    assign complete        = wrap && act_oneshot && (tick_cnt == act_nticks - TICK_W'(1));
    assign launch          = idle_like && start && !stop;

    // State register.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop beats pause beats start.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = (act_oneshot && act_nticks == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (complete) begin
                        state_d = S_DONE;
                    end else if (pause) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Divide counter, tick pulse, square wave and one-shot tick budget.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            count     <= '0;
            tick_cnt  <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (stop || launch) begin
                count     <= '0;
                tick_cnt  <= '0;
                clk_out_q <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (wrap) begin
                    count     <= '0;
                    tick_q    <= 1'b1;
                    clk_out_q <= ~clk_out_q;
                    if (complete) begin
                        tick_cnt <= '0;
                    end else if (tick_cnt != '1) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    // Config handshake: direct load when idle, otherwise park in pending until the next tick.
    always_ff @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) begin
            act_div      <= CNT_W'(DEFAULT_DIV);
            act_oneshot  <= 1'b0;
            act_nticks   <= '0;
            pend_div     <= '0;
            pend_oneshot <= 1'b0;
            pend_nticks  <= '0;
            pend_valid   <= 1'b0;
        end else begin
            if (cfg_accept && idle_like) begin
                act_div     <= cfg_div_clamped;
                act_oneshot <= cfg_oneshot;
                act_nticks  <= cfg_nticks;
            end else if (wrap && pend_valid) begin
                act_div     <= pend_div;
                act_oneshot <= pend_oneshot;
                act_nticks  <= pend_nticks;
            end

            if (stop) begin
                pend_valid <= 1'b0;
            end else if (wrap && pend_valid) begin
                pend_valid <= 1'b0;
            end else if (cfg_accept && !idle_like) begin
                pend_valid   <= 1'b1;
                pend_div     <= cfg_div_clamped;
                pend_oneshot <= cfg_oneshot;
                pend_nticks  <= cfg_nticks;
            end
        end
    end

    assign cfg_ready = !pend_valid;
    assign tick      = tick_q;
    assign clk_out   = clk_out_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done      = (state_q == S_DONE);
    assign state     = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl against a behavioural run-time model
module tb_clk_div_ctrl;

    localparam int DEF = 4;

    logic        clk = 1'b0;
    logic        rst_n_a;
    logic        start, stop, pause;
    logic        cfg_valid, cfg_ready, cfg_oneshot;
    logic [31:0] cfg_div;
    logic [15:0] cfg_nticks;
    logic        tick, clk_out, busy, done;
    logic [1:0]  state;

    clk_div_ctrl #(
        .CLK_FREQ   (50_000_000),
        .DEFAULT_DIV(DEF),
        .CNT_W      (32),
        .TICK_W     (16)
    ) dut (
        .clk        (clk),
        .rst_n_a    (rst_n_a),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .cfg_nticks (cfg_nticks),
        .tick       (tick),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: state (0 idle,1 run,2 pause,3 done), run edges since period origin, ticks emitted.
    int   m_st, m_r, m_ticks;
    int   m_d, m_nt, p_d, p_nt;
    bit   m_os, p_os, m_pend, m_clk, m_tick;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_r = 0; m_ticks = 0; m_d = DEF; m_os = 0; m_nt = 0;
        m_pend = 0; m_clk = 0; m_tick = 0;
    endtask

    task automatic clear_in();
        start = 0; stop = 0; pause = 0; cfg_valid = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tick"}, tick, m_tick);
        chk({tag, ".clk_out"}, clk_out, m_clk);
        chk({tag, ".state"}, state, m_st);
        chk({tag, ".busy"}, busy, (m_st == 1 || m_st == 2));
        chk({tag, ".done"}, done, (m_st == 3));
        chk({tag, ".cfg_ready"}, cfg_ready, !m_pend);
    endtask

    // Predict the effect of the currently driven inputs, advance one edge, compare.
    task automatic step(input string tag);
        bit acc;
        int cd, old;
        acc = cfg_valid && !m_pend;
        cd = (cfg_div == 0) ? 1 : int'(cfg_div);
        old = m_st;
        m_tick = 0;
        if (old == 0 || old == 3) begin
            if (stop) begin
                m_st = 0; m_r = 0; m_ticks = 0; m_clk = 0;
            end else if (start) begin
                m_st = (m_os && m_nt == 0) ? 3 : 1;
                m_r = 0; m_ticks = 0; m_clk = 0;
            end
            if (acc) begin
                m_d = cd; m_os = cfg_oneshot; m_nt = cfg_nticks;
            end
        end else if (stop) begin
            m_st = 0; m_r = 0; m_ticks = 0; m_clk = 0; m_pend = 0;
        end else begin
            if (old == 1) begin
                m_r++;
                if (m_r % m_d == 0) begin
                    m_tick = 1;
                    m_clk = !m_clk;
                    m_ticks++;
                    if (m_os && m_ticks == m_nt) begin
                        m_st = 3;
                        m_ticks = 0;
                    end
                    if (m_pend) begin
                        m_d = p_d; m_os = p_os; m_nt = p_nt; m_pend = 0; m_r = 0;
                    end
                end
                if (m_st == 1 && pause) m_st = 2;
            end else if (start) begin
                m_st = 1;
            end
            if (acc) begin
                m_pend = 1; p_d = cd; p_os = cfg_oneshot; p_nt = cfg_nticks;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic cfg(input int d, input bit os, input int nt);
        cfg_valid = 1; cfg_div = d; cfg_oneshot = os; cfg_nticks = nt;
        step("cfg");
        cfg_valid = 0;
    endtask

    task automatic go(input string tag);
        start = 1; step(tag); start = 0;
    endtask

    task automatic halt();
        stop = 1; step("stop"); stop = 0;
    endtask

    int tick_total;

    initial begin
        clear_in();
        cfg_div = 0; cfg_oneshot = 0; cfg_nticks = 0;
        rst_n_a = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n_a = 1;

        // Default divide ratio: ticks at 4, 8, 12 after the start edge.
        go("def_start");
        tick_total = 0;
        for (int e = 1; e <= 12; e++) begin
            step("def_run");
            tick_total += tick;
            chk("def_tick_edge", tick, (e % DEF == 0));
        end
        chk("def_tick_total", tick_total, 3);
        halt();

        // D=3, pause for 10 edges after the 2nd tick, then resume.
        cfg(3, 0, 0);
        go("p_start");
        run("p_run", 6);
        pause = 1; step("p_pause"); pause = 0;
        run("p_hold", 10);
        go("p_resume");
        run("p_after", 8);
        halt();

        // D=5 running, D=2 pushed mid-period.
        cfg(5, 0, 0);
        go("c_start");
        run("c_run", 2);
        cfg_valid = 1; cfg_div = 2; step("c_push"); cfg_valid = 0;
        chk("c_ready_low", cfg_ready, 0);
        run("c_drain", 12);
        halt();

        // One-shot: 3 ticks at D=2, again after restart, then nticks=0.
        cfg(2, 1, 3);
        go("o_start");
        run("o_run", 9);
        chk("o_done", done, 1);
        go("o_restart");
        run("o_run2", 9);
        cfg(2, 1, 0);
        go("o_zero");
        chk("o_zero_state", state, 3);
        run("o_zero_hold", 3);
        halt();
        cfg(3, 0, 0);

        // stop+pause+start together while a config is pending.
        go("s_start");
        run("s_run", 4);
        cfg_valid = 1; cfg_div = 6; step("s_push"); cfg_valid = 0;
        stop = 1; pause = 1; start = 1; step("s_all"); clear_in();
        chk("s_state_idle", state, 0);
        go("s_restart");
        run("s_old_div", 7);
        halt();

        // Async reset mid-RUN with cfg_div=0 pending.
        go("r_start");
        run("r_run", 2);
        cfg_valid = 1; cfg_div = 0; step("r_push"); cfg_valid = 0;
        #3 rst_n_a = 0;
        #1;
        m_reset();
        check_all("r_async");
        @(negedge clk);
        rst_n_a = 1;
        go("r_restart");
        run("r_default", 10);
        halt();

        // cfg_div=0 accepted in IDLE: tick every cycle.
        cfg(0, 0, 0);
        go("z_start");
        run("z_run", 5);
        chk("z_tick", tick, 1);
        halt();

        // Randomized sequences.
        for (int it = 0; it < 10; it++) begin
            halt();
            cfg($urandom_range(1, 6), $urandom_range(0, 1), $urandom_range(0, 4));
            go("rnd_start");
            for (int c = 0; c < 40; c++) begin
                clear_in();
                if (m_st == 1 && $urandom_range(0, 5) == 0) pause = 1;
                if (m_st == 2 && $urandom_range(0, 2) == 0) start = 1;
                if (m_st == 3 && $urandom_range(0, 4) == 0) start = 1;
                if (m_st == 1 && !m_pend && $urandom_range(0, 9) == 0) begin
                    cfg_valid = 1;
                    cfg_div = $urandom_range(0, 6);
                    cfg_oneshot = $urandom_range(0, 1);
                    cfg_nticks = $urandom_range(1, 4);
                end
                step("rnd");
            end
            clear_in();
        end
        halt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
